// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// Module: id_ex_stage
// ID/EX pipeline register with built-in load-use hazard detection.
//
// The register captures the decoded operands, register indices, immediate,
// PC and control bundle from ID and presents them to EX. When the load in EX
// writes a register that the ID instruction reads, the register inserts one
// bubble. It also raises stall_o so that the PC and IF/ID hold the dependent
// instruction for one more cycle. A branch/jump redirect (flush) squashes the
// entry.
//
// Optional feature macro: IDEX_WB_BYPASS_EN
//   defined   : a same-cycle MEM/WB write to rs1/rs2 replaces the register
//               file read data as the value is captured.
//   undefined : the read data is captured as is, and the wb_* inputs are unused.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   id_valid              ID holds a real instruction
//   id_pc                 PC of the ID instruction
//   id_rs1/rs2/rd         register indices
//   id_uses_rs1/rs2       instruction actually reads rs1/rs2
//   id_rs1_data/rs2_data  register file read data
//   id_imm                sign-extended immediate
//   id_ctrl               [0]regwrite [1]memread [2]memwrite [3]memtoreg
//                         [4]alusrc [8:5]aluop
//   flush                 redirect: load a bubble
//   hold                  external freeze: keep all registers unchanged
//   wb_regwrite/rd/data   MEM/WB write port (used only by the bypass)
//   ex_*                  registered copies of the fields above for EX
//   stall_o               load-use stall request (combinational)
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_o
);

  logic            hz;
  logic            rs1_hit;
  logic            rs2_hit;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;

  // A load in EX (memread = ctrl[1]) that targets a register the ID
  // instruction reads must wait one cycle for its data. While reset is
  // asserted, the registers are zero, so hz is low as well.
  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
  assign hz      = ex_valid && ex_ctrl[1] && (ex_rd != 5'd0) && id_valid &&
                   (rs1_hit || rs2_hit);

  // A redirect throws the dependent instruction away, so no stall is needed.
  assign stall_o = hz && !flush;

`ifdef IDEX_WB_BYPASS_EN
  // Forward a MEM/WB write that lands in the same cycle as the register read.
  always_comb begin
    rs1_data_in = id_rs1_data;
    rs2_data_in = id_rs2_data;
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs1))
      rs1_data_in = wb_data;
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs2))
      rs2_data_in = wb_data;
  end
`else
  logic unused_wb;

  assign rs1_data_in = id_rs1_data;
  assign rs2_data_in = id_rs2_data;
  assign unused_wb   = ^{wb_regwrite, wb_rd, wb_data};
`endif

  // Flush beats hold, and hold beats the hazard bubble. A bubble and an
  // invalid ID slot both clear every field, so a dead entry never matches
  // in forwarding, never writes the register file and never touches memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
    end else if (!flush && hold) begin
      ex_valid    <= ex_valid;
    end else if (flush || hz || !id_valid) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= rs1_data_in;
      ex_rs2_data <= rs2_data_in;
      ex_imm      <= id_imm;
      ex_ctrl     <= id_ctrl;
    end
  end

endmodule
